// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue stage.
//   op_t          : shift opcode encoding seen on in_op
//   entry_t       : one queued request {op, a, amt} at the default width
//   DEFAULT_WIDTH : default datapath width used by shift_issue and shift_core
package shift_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  typedef struct packed {
    op_t                      op;
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] amt;
  } entry_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shift core with saturation on oversized amounts.
//   op     : opcode (SLL / SRL / SRA / reserved)
//   a      : operand
//   amt    : full-width shift amount; any set bit above the low log2(WIDTH)
//            bits saturates the shift
//   result : shifted value (operand passes through on the reserved opcode)
//   zero   : result is all zeros
//   err    : reserved opcode was used
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] s_s;
  logic          big_s;

  assign s_s   = amt[SW-1:0];
  assign big_s = |amt[WIDTH-1:SW];
  assign zero  = (result == {WIDTH{1'b0}});

  // Opcode decode and saturating shift selection.
  always_comb begin
    result = a;
    err    = 1'b0;
    case (op)
      OP_SLL: begin
        if (big_s) begin
          result = {WIDTH{1'b0}};
        end else begin
          result = a << s_s;
        end
      end
      OP_SRL: begin
        if (big_s) begin
          result = {WIDTH{1'b0}};
        end else begin
          result = a >> s_s;
        end
      end
      OP_SRA: begin
        if (big_s) begin
          result = {WIDTH{a[WIDTH-1]}};
        end else begin
          result = $unsigned($signed(a) >>> s_s);
        end
      end
      OP_RSV: begin
        result = a;
        err    = 1'b1;
      end
      default: begin
        result = a;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shift_issue.sv
// Shift issue stage: buffers shift requests in a DEPTH-entry FIFO, runs the
// head entry through shift_core and holds the result in an output register.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : request handshake (in_ready is registered)
//   in_op, in_a, in_amt : request fields
//   out_valid/out_ready : result handshake
//   out_result, out_zero, out_err : registered shift result and flags
//   accept_cnt        : wrapping count of accepted requests
module shift_issue
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err,
  output logic [15:0]      accept_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Width-parameterised equivalent of shift_pkg::entry_t.
  typedef struct packed {
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] amt;
  } slot_t;

  slot_t            mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_result_r;
  logic             out_zero_r;
  logic             out_err_r;
  logic [15:0]      accept_cnt_r;

  logic             push_s;
  logic             load_s;
  slot_t            head_s;
  logic [WIDTH-1:0] core_result_s;
  logic             core_zero_s;
  logic             core_err_s;

  // in_ready_r always mirrors count_r != DEPTH, so a full FIFO never pushes.
  assign push_s = in_valid && in_ready_r;
  assign load_s = (count_r != {CW{1'b0}}) && (!out_valid_r || out_ready);
  assign head_s = mem_r[rd_ptr_r];

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (head_s.op),
    .a      (head_s.a),
    .amt    (head_s.amt),
    .result (core_result_s),
    .zero   (core_zero_s),
    .err    (core_err_s)
  );

  // Next occupancy from the push/load pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, load_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and registered in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{op: OP_SLL, a: {WIDTH{1'b0}}, amt: {WIDTH{1'b0}}};
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{op: op_t'(in_op), a: in_a, amt: in_amt};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != CW'(DEPTH));
    end
  end

  // Output register: load from the head, hold under backpressure, drop when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {WIDTH{1'b0}};
      out_zero_r   <= 1'b1;
      out_err_r    <= 1'b0;
    end else if (load_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= core_result_s;
      out_zero_r   <= core_zero_s;
      out_err_r    <= core_err_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

  // Accepted-request counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt_r <= 16'h0000;
    end else if (push_s) begin
      accept_cnt_r <= accept_cnt_r + 16'h0001;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_zero   = out_zero_r;
  assign out_err    = out_err_r;
  assign accept_cnt = accept_cnt_r;

endmodule

// File: tb/tb_shift_issue.sv
// Self-checking bench for shift_issue (WIDTH=32, DEPTH=2): a queue-based
// model checked every cycle, plus directed literal expectations.
module tb_shift_issue;

  localparam int W = 32;
  localparam int D = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_amt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_zero;
  logic          out_err;
  logic [15:0]   accept_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  shift_issue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_amt     (in_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift written from the arithmetic rules.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] amt);
    if (op == 2'b11) return a;
    if (amt >= 32'd32) begin
      if (op == 2'b10 && a[31]) return 32'hFFFF_FFFF;
      return 32'h0;
    end
    case (op)
      2'b00:   return a << amt;
      2'b01:   return a >> amt;
      default: return a[31] ? ~((~a) >> amt) : (a >> amt);
    endcase
  endfunction

  // Model state: requests waiting ahead of the output register, plus that register.
  typedef struct { logic [31:0] r; logic z; logic e; } res_t;
  res_t q[$];
  res_t m_out;
  bit   m_ov;
  bit   m_ir;
  int   m_total;
  bit   live = 1'b0;

  always @(posedge clk) begin
    bit   push;
    bit   load;
    res_t n;
    if (rst) begin
      q.delete();
      m_out   = '{32'h0, 1'b1, 1'b0};
      m_ov    = 1'b0;
      m_ir    = 1'b1;
      m_total = 0;
      live    = 1'b1;
    end else if (live) begin
      push = in_valid && m_ir;
      load = (q.size() != 0) && (!m_ov || out_ready);
      if (load) begin
        m_out = q.pop_front();
        m_ov  = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (push) begin
        n.r = ref_shift(in_op, in_a, in_amt);
        n.z = (n.r == 32'h0);
        n.e = (in_op == 2'b11);
        q.push_back(n);
        m_total++;
      end
      m_ir = (q.size() != D);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      check("in_ready",   {31'b0, in_ready},  {31'b0, m_ir});
      check("out_valid",  {31'b0, out_valid}, {31'b0, m_ov});
      check("out_result", out_result,         m_out.r);
      check("out_zero",   {31'b0, out_zero},  {31'b0, m_out.z});
      check("out_err",    {31'b0, out_err},   {31'b0, m_out.e});
      check("accept_cnt", {16'b0, accept_cnt}, {16'b0, m_total[15:0]});
    end
  end

  task automatic set_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] amt);
    in_op  = op;
    in_a   = a;
    in_amt = amt;
  endtask

  // Hold a request valid until accepted (bounded); returns at the negedge after acceptance.
  task automatic push_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] amt);
    bit took;
    took = 1'b0;
    set_req(op, a, amt);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      took = in_ready;
      @(negedge clk);
      if (took) break;
    end
    in_valid = 1'b0;
    check("push_accept", {31'b0, took}, 32'd1);
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] amt, input logic [31:0] er,
                          input logic ez, input logic ee);
    out_ready = 1'b1;
    push_one(op, a, amt);
    @(negedge clk);
    check({name, "_valid"},  {31'b0, out_valid}, 32'd1);
    check({name, "_result"}, out_result, er);
    check({name, "_zero"},   {31'b0, out_zero}, {31'b0, ez});
    check({name, "_err"},    {31'b0, out_err},  {31'b0, ee});
  endtask

  task automatic rand_req();
    logic [31:0] amt;
    case ($urandom_range(0, 4))
      0:       amt = 32'($urandom_range(0, 31));
      1:       amt = 32'd31;
      2:       amt = 32'd32;
      3:       amt = 32'($urandom);
      default: amt = 32'd0;
    endcase
    set_req(2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0) ? 32'h0 : 32'($urandom), amt);
  endtask

  initial begin
    bit took;
    int acc;
    int start;
    int cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_in_ready",   {31'b0, in_ready},  32'd1);
    check("rst_out_valid",  {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result,         32'h0);
    check("rst_out_zero",   {31'b0, out_zero},  32'd1);
    check("rst_out_err",    {31'b0, out_err},   32'd0);
    check("rst_accept_cnt", {16'b0, accept_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    directed("sll1",    2'b00, 32'h0000_0001, 32'd4,         32'h0000_0010, 1'b0, 1'b0);
    directed("sra_sat", 2'b10, 32'h8000_0000, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 1'b0);
    directed("srl_sat", 2'b01, 32'h8000_0000, 32'h0000_0020, 32'h0000_0000, 1'b1, 1'b0);
    directed("sll_sat", 2'b00, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0);
    directed("rsv",     2'b11, 32'h1234_5678, 32'd3,         32'h1234_5678, 1'b0, 1'b1);
    directed("sll_after_rsv", 2'b00, 32'h0000_00F0, 32'd8,   32'h0000_F000, 1'b0, 1'b0);
    directed("sra_small", 2'b10, 32'hF000_0000, 32'd4,       32'hFF00_0000, 1'b0, 1'b0);

    // Backpressure: four back-to-back requests with the consumer stalled.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      set_req(2'b00, 32'(k + 1), 32'(k));
      in_valid = 1'b1;
      took = in_ready;
      @(negedge clk);
      if (took) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd3);
    check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    took = 1'b0;
    for (int i = 0; i < 20; i++) begin
      took = in_ready;
      @(negedge clk);
      if (took) break;
    end
    in_valid = 1'b0;
    check("bp_fourth_accept", {31'b0, took}, 32'd1);
    check("bp_accept_cnt", {16'b0, accept_cnt}, 32'd4);
    repeat (6) @(negedge clk);

    // Reset with two entries queued and a held result.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(2'b01, 32'hA000_0000 + 32'(k), 32'd1);
      @(negedge clk);
    end
    check("mid_out_valid_pre", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_in_ready",  {31'b0, in_ready},  32'd1);
    check("mid_accept_cnt", {16'b0, accept_cnt}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_stale", {31'b0, out_valid}, 32'd0);
    end

    // Random valid/ready toggling.
    start = m_total;
    cyc   = 0;
    while ((m_total - start) < 2000 && cyc < 12000) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 60);
      rand_req();
      @(negedge clk);
      cyc++;
    end
    check("rand_progress", {31'b0, (m_total - start) >= 2000}, 32'd1);

    // Full-rate burst to carry accept_cnt past its wrap.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    while (m_total < 65600 && cyc < 70000) begin
      rand_req();
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("wrap_reached", {31'b0, m_total >= 65600}, 32'd1);
    check("wrap_accept_cnt", {16'b0, accept_cnt}, 32'(m_total - 65536));
    repeat (6) @(negedge clk);
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
